// File: rtl/gpio_ctrl_if.sv
// Single-bit configuration access channel between the APB bridge and gpio_ctrl.
interface gpio_ctrl_if;
  localparam int unsigned PIN_W  = 5;
  localparam int unsigned CFG_W  = 3;
  localparam int unsigned DATA_W = 32;

  logic              write;
  logic              read;
  logic [PIN_W-1:0]  add_pin_number;
  logic [CFG_W-1:0]  add_config;
  logic              data_in;
  logic [DATA_W-1:0] data_out;
  logic              write_done;
  logic              read_done;

  // Bridge side: issues requests and holds them until acknowledged.
  modport master (
    output write,
    output read,
    output add_pin_number,
    output add_config,
    output data_in,
    input  data_out,
    input  write_done,
    input  read_done
  );

  // Controller side: services one request at a time.
  modport slave (
    input  write,
    input  read,
    input  add_pin_number,
    input  add_config,
    input  data_in,
    output data_out,
    output write_done,
    output read_done
  );
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO controller: per-pin config bits, input synchroniser, edge interrupts,
// sticky pending flags and a single aggregated interrupt line.
module gpio_ctrl #(
  parameter int unsigned NUM_PINS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gpio_ctrl_if.slave          bus,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic [NUM_PINS-1:0] pin_pu,
  output logic [NUM_PINS-1:0] pin_pd,
  output logic                irq
);

  localparam int unsigned PIN_W   = 5;
  localparam int unsigned CFG_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_CFG = 8;
  localparam int unsigned PAD_W   = DATA_W - PIN_W - CFG_W - 1;
  localparam int unsigned WARM_W  = 3;

  localparam logic [CFG_W-1:0] CFG_DIR   = 3'd0;
  localparam logic [CFG_W-1:0] CFG_DATA  = 3'd1;
  localparam logic [CFG_W-1:0] CFG_INTS0 = 3'd2;
  localparam logic [CFG_W-1:0] CFG_INTS1 = 3'd3;
  localparam logic [CFG_W-1:0] CFG_PUR   = 3'd4;
  localparam logic [CFG_W-1:0] CFG_PDR   = 3'd5;
  localparam logic [CFG_W-1:0] CFG_IN    = 3'd6;
  localparam logic [CFG_W-1:0] CFG_PEND  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Per-pin configuration and status fields
  logic [NUM_PINS-1:0] dir_q,   dir_d;
  logic [NUM_PINS-1:0] data_q,  data_d;
  logic [NUM_PINS-1:0] ints0_q, ints0_d;
  logic [NUM_PINS-1:0] ints1_q, ints1_d;
  logic [NUM_PINS-1:0] pur_q,   pur_d;
  logic [NUM_PINS-1:0] pdr_q,   pdr_d;
  logic [NUM_PINS-1:0] pend_q,  pend_d;
  logic [NUM_PINS-1:0] pend_clr;
  logic [NUM_PINS-1:0] pend_set;

  // Input path
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] in_sync;
  logic [NUM_PINS-1:0] in_prev_q;
  logic [NUM_PINS-1:0] in_rise;
  logic [NUM_PINS-1:0] in_fall;
  logic [WARM_W-1:0]   warm_q;

  // Handshake outputs
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              write_done_q, write_done_d;
  logic              read_done_q, read_done_d;
  logic              wr_en;
  logic              start_wr;
  logic              start_rd;

  // Read path
  logic [DATA_W-1:0] cfg_ext [NUM_CFG];
  logic              rd_bit;
  logic [DATA_W-1:0] rd_word;

  assign in_sync = sync_q[SYNC_STAGES-1];

  // Write wins over read; a request whose done flag is still high is ignored.
  assign start_wr = bus.write && !write_done_q;
  assign start_rd = !start_wr && bus.read && !read_done_q;

  // Zero-extended field views so out-of-range pin indices read back as 0.
  always_comb begin
    cfg_ext[CFG_DIR]   = DATA_W'(dir_q);
    cfg_ext[CFG_DATA]  = DATA_W'(data_q);
    cfg_ext[CFG_INTS0] = DATA_W'(ints0_q);
    cfg_ext[CFG_INTS1] = DATA_W'(ints1_q);
    cfg_ext[CFG_PUR]   = DATA_W'(pur_q);
    cfg_ext[CFG_PDR]   = DATA_W'(pdr_q);
    cfg_ext[CFG_IN]    = DATA_W'(in_sync);
    cfg_ext[CFG_PEND]  = DATA_W'(pend_q);
  end

  assign rd_bit  = cfg_ext[bus.add_config][bus.add_pin_number];
  assign rd_word = {{PAD_W{1'b0}}, rd_bit, bus.add_config, bus.add_pin_number};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = WRITE;
        end else if (start_rd) begin
          state_d = READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: done flags, read capture and the write strobe
  always_comb begin
    wr_en        = 1'b0;
    write_done_d = write_done_q;
    read_done_d  = read_done_q;
    data_out_d   = data_out_q;
    case (state_q)
      IDLE: begin
        write_done_d = write_done_q & bus.write;
        read_done_d  = read_done_q & bus.read;
        if (start_rd) begin
          data_out_d = rd_word;
        end
      end
      WRITE: begin
        wr_en        = 1'b1;
        write_done_d = 1'b1;
      end
      READ: begin
        read_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      write_done_q <= 1'b0;
      read_done_q  <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      write_done_q <= write_done_d;
      read_done_q  <= read_done_d;
    end
  end

  // Input synchroniser and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      in_prev_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      in_prev_q <= in_sync;
    end
  end

  // Warm-up counter masks edges while the synchroniser fills after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= WARM_W'(SYNC_STAGES + 1);
    end else if (warm_q != '0) begin
      warm_q <= warm_q - WARM_W'(1);
    end
  end

  // Qualifying edges per pin
  always_comb begin
    in_rise  = in_sync & ~in_prev_q;
    in_fall  = ~in_sync & in_prev_q;
    pend_set = '0;
    if (warm_q == '0) begin
      pend_set = (in_rise & ints0_q) | (in_fall & ints1_q);
    end
  end

  // Config write decode; PEND is W1C and a same-cycle edge wins
  always_comb begin
    dir_d    = dir_q;
    data_d   = data_q;
    ints0_d  = ints0_q;
    ints1_d  = ints1_q;
    pur_d    = pur_q;
    pdr_d    = pdr_q;
    pend_clr = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (wr_en && (bus.add_pin_number == PIN_W'(i))) begin
        case (bus.add_config)
          CFG_DIR:   dir_d[i]   = bus.data_in;
          CFG_DATA:  data_d[i]  = bus.data_in;
          CFG_INTS0: ints0_d[i] = bus.data_in;
          CFG_INTS1: ints1_d[i] = bus.data_in;
          CFG_PUR: begin
            pur_d[i] = bus.data_in;
            if (bus.data_in) begin
              pdr_d[i] = 1'b0;
            end
          end
          CFG_PDR: begin
            pdr_d[i] = bus.data_in;
            if (bus.data_in) begin
              pur_d[i] = 1'b0;
            end
          end
          CFG_PEND:  pend_clr[i] = bus.data_in;
          default: ;
        endcase
      end
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  // Config and pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= '0;
      data_q  <= '0;
      ints0_q <= '0;
      ints1_q <= '0;
      pur_q   <= '0;
      pdr_q   <= '0;
      pend_q  <= '0;
    end else begin
      dir_q   <= dir_d;
      data_q  <= data_d;
      ints0_q <= ints0_d;
      ints1_q <= ints1_d;
      pur_q   <= pur_d;
      pdr_q   <= pdr_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.write_done = write_done_q;
  assign bus.read_done  = read_done_q;

  assign pin_out = data_q;
  assign pin_oe  = dir_q;
  assign pin_pu  = pur_q;
  assign pin_pd  = pdr_q;
  assign irq     = |pend_q;

endmodule
